// File: rtl/display_queue_if.sv
// Bus-side bundle of the paced display queue: write strobe/data in, queue status and pins out.
interface display_queue_if #(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 8,
    parameter int DEPTH      = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  in_en;
    logic [DATA_WIDTH-1:0] in;
    logic                  full;
    logic                  empty;
    logic [CNT_W-1:0]      count;
    logic                  busy;
    logic                  overflow;
    logic [OUT_WIDTH-1:0]  out;

    modport master (
        output in_en, in,
        input  full, empty, count, busy, overflow, out
    );

    modport slave (
        input  in_en, in,
        output full, empty, count, busy, overflow, out
    );
endinterface

// File: rtl/display_queue.sv
// Queued, paced LED output: bus words are buffered in a FIFO and shown slice by slice, each slice held HOLD_CYCLES.
// DISPLAY_QUEUE_SPLIT_EN: defined -> every OUT_WIDTH slice shown MS first; undefined -> only the low slice is shown.
module display_queue #(
    parameter int                   DATA_WIDTH  = 16,
    parameter int                   OUT_WIDTH   = 8,
    parameter int                   DEPTH       = 4,
    parameter int                   HOLD_CYCLES = 1000,
    parameter logic [OUT_WIDTH-1:0] RESET_VALUE = 8'h55
) (
    input  logic            clk,
    input  logic            rst,
    display_queue_if.slave  bus
);
`ifdef DISPLAY_QUEUE_SPLIT_EN
    localparam int SLICES = DATA_WIDTH / OUT_WIDTH;
`else
    localparam int SLICES = 1;
`endif
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int SLC_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    // Unsplit mode parks the low slice at the top so one extraction path serves both builds.
    localparam int ALIGN  = (SLICES == 1) ? (DATA_WIDTH - OUT_WIDTH) : 0;

    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [SLC_W-1:0]  LAST_SLICE  = SLC_W'(SLICES - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT   = CNT_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d, empty_q, empty_d;
    logic                  overflow_q, overflow_d;
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [SLC_W-1:0]      slice_q, slice_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [OUT_WIDTH-1:0]  out_q, out_d;
    logic                  busy_q, busy_d;
    logic                  push_s, pop_s;
    logic [DATA_WIDTH-1:0] head_s;

    // FIFO bookkeeping: full is the pre-edge value, so a same-cycle pop never rescues a write.
    always_comb begin
        push_s     = bus.in_en & ~full_q;
        overflow_d = overflow_q | (bus.in_en & full_q);
        wr_ptr_d   = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d   = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
    end

    // Display FSM: pops the head, walks slices MS first and reloads the hold counter per slice.
    always_comb begin
        head_s  = mem_q[rd_ptr_q] << ALIGN;
        state_d = state_q;
        shift_d = shift_q;
        slice_d = slice_q;
        hold_d  = hold_q;
        out_d   = out_q;
        pop_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    slice_d = '0;
                    out_d   = head_s[DATA_WIDTH-1 -: OUT_WIDTH];
                    hold_d  = HOLD_RELOAD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (slice_q != LAST_SLICE) begin
                    shift_d = shift_q << OUT_WIDTH;
                    slice_d = slice_q + SLC_W'(1);
                    out_d   = shift_d[DATA_WIDTH-1 -: OUT_WIDTH];
                    hold_d  = HOLD_RELOAD;
                end else if (count_q != '0) begin
                    pop_s   = 1'b1;
                    shift_d = head_s;
                    slice_d = '0;
                    out_d   = head_s[DATA_WIDTH-1 -: OUT_WIDTH];
                    hold_d  = HOLD_RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_HOLD);
    end

    // State, pointer and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            slice_q    <= '0;
            hold_q     <= '0;
            out_q      <= RESET_VALUE;
            busy_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            slice_q    <= slice_d;
            hold_q     <= hold_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
        end
    end

    // FIFO storage; contents need no reset since the pointers gate every read.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= bus.in;
        end
    end

    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.count    = count_q;
    assign bus.busy     = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.out      = out_q;
endmodule

// File: tb/tb_display_queue.sv
// Directed bench for display_queue (DEPTH=4, HOLD_CYCLES=5); expectations follow DISPLAY_QUEUE_SPLIT_EN.
module tb_display_queue;
    localparam int H = 5;
`ifdef DISPLAY_QUEUE_SPLIT_EN
    localparam int S = 2;
`else
    localparam int S = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] words [0:5];

    always #5 clk = ~clk;

    display_queue_if #(.DATA_WIDTH(16), .OUT_WIDTH(8), .DEPTH(4)) bus ();

    display_queue #(
        .DATA_WIDTH (16),
        .OUT_WIDTH  (8),
        .DEPTH      (4),
        .HOLD_CYCLES(H),
        .RESET_VALUE(8'h55)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Slice k of word w as it should appear on the pins.
    function automatic logic [7:0] exp_slice(input logic [15:0] w, input int k);
`ifdef DISPLAY_QUEUE_SPLIT_EN
        return (k == 0) ? w[15:8] : w[7:0];
`else
        return w[7:0];
`endif
    endfunction

    // Pin value c cycles after the first word of the burst was popped.
    function automatic logic [7:0] exp_at(input int c);
        return exp_slice(words[c / (S * H)], (c / H) % S);
    endfunction

    initial begin
        words[0] = 16'hA101; words[1] = 16'hB202; words[2] = 16'hC303;
        words[3] = 16'hD404; words[4] = 16'hE505; words[5] = 16'hF606;
        bus.in_en = 1'b0;
        bus.in    = 16'h0000;

        // Two reset cycles, the second with a write that reset must override.
        rst = 1'b1;
        tick();
        bus.in_en = 1'b1;
        bus.in    = 16'hFFFF;
        tick();
        rst = 1'b0;
        bus.in_en = 1'b0;
        check("rst_out", bus.out, 32'h55);
        check("rst_empty", bus.empty, 32'd1);
        check("rst_full", bus.full, 32'd0);
        check("rst_count", bus.count, 32'd0);
        check("rst_busy", bus.busy, 32'd0);
        check("rst_overflow", bus.overflow, 32'd0);
        tick();
        check("idle_out", bus.out, 32'h55);
        check("idle_busy", bus.busy, 32'd0);

        // Single word: queued first, popped one edge later, each slice held H cycles.
        bus.in_en = 1'b1;
        bus.in    = 16'h1234;
        tick();
        bus.in_en = 1'b0;
        check("w1_count", bus.count, 32'd1);
        check("w1_empty", bus.empty, 32'd0);
        check("w1_busy_pre", bus.busy, 32'd0);
        check("w1_out_pre", bus.out, 32'h55);
        tick();
        check("w1_count_pop", bus.count, 32'd0);
        check("w1_busy", bus.busy, 32'd1);
        check("w1_out0", bus.out, {24'd0, exp_slice(16'h1234, 0)});
        for (int c = 1; c < S * H; c++) begin
            tick();
            check("w1_out", bus.out, {24'd0, exp_slice(16'h1234, c / H)});
            check("w1_busy_hold", bus.busy, 32'd1);
        end
        tick();
        check("w1_busy_end", bus.busy, 32'd0);
        check("w1_out_end", bus.out, {24'd0, exp_slice(16'h1234, S - 1)});
        repeat (3) tick();
        check("w1_out_keep", bus.out, {24'd0, exp_slice(16'h1234, S - 1)});
        check("w1_busy_keep", bus.busy, 32'd0);
        check("w1_empty_end", bus.empty, 32'd1);

        // Burst of six writes: first pops, four fill the queue, sixth is dropped.
        for (int k = 0; k < 6; k++) begin
            bus.in_en = 1'b1;
            bus.in    = words[k];
            tick();
            if (k >= 1) begin
                check("bu_out", bus.out, {24'd0, exp_at(k - 1)});
                check("bu_busy", bus.busy, 32'd1);
            end
            if (k == 4) begin
                check("bu_full", bus.full, 32'd1);
                check("bu_count4", bus.count, 32'd4);
                check("bu_no_ovf", bus.overflow, 32'd0);
            end
            if (k == 5) begin
                check("bu_ovf", bus.overflow, 32'd1);
                check("bu_count_drop", bus.count, 32'd4);
                check("bu_full_drop", bus.full, 32'd1);
            end
        end
        bus.in_en = 1'b0;
        for (int c = 5; c < 5 * S * H; c++) begin
            tick();
            check("bu_out", bus.out, {24'd0, exp_at(c)});
            check("bu_busy", bus.busy, 32'd1);
        end
        tick();
        check("bu_busy_end", bus.busy, 32'd0);
        check("bu_empty_end", bus.empty, 32'd1);
        check("bu_count_end", bus.count, 32'd0);
        check("bu_out_end", bus.out, {24'd0, exp_slice(words[4], S - 1)});
        check("bu_ovf_sticky", bus.overflow, 32'd1);

        // Reset in the second hold cycle of a slice with two words queued.
        bus.in_en = 1'b1;
        bus.in    = 16'h0102;
        tick();
        bus.in    = 16'h0304;
        tick();
        bus.in    = 16'h0506;
        tick();
        bus.in_en = 1'b0;
        check("mr_count", bus.count, 32'd2);
        check("mr_out", bus.out, {24'd0, exp_slice(16'h0102, 0)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_out_rst", bus.out, 32'h55);
        check("mr_count_rst", bus.count, 32'd0);
        check("mr_busy_rst", bus.busy, 32'd0);
        check("mr_empty_rst", bus.empty, 32'd1);
        check("mr_ovf_rst", bus.overflow, 32'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            check("mr_out_quiet", bus.out, 32'h55);
            check("mr_busy_quiet", bus.busy, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
